// File: rtl/mem_access_51.sv
// -----------------------------------------------------------------------------
// mem_access_51 -- load/store unit between a pipeline request port and a
// single-port, word-organised data memory (combinational read, one write port).
//
// Requests are byte addressed. Sub-word stores are done as read-modify-write,
// so the other bytes of the word keep their values.
//
// Parameter
//   ADDR_LIMIT      highest valid word index of the attached memory
//
// Ports
//   clk_51          clock, rising edge
//   rst_n_51        synchronous active-low reset
//   req_valid_51    request present           req_ready_51  accepting (IDLE only)
//   req_we_51       1 store / 0 load          req_size_51   00 B, 01 H, 10 W, 11 illegal
//   req_signed_51   sign-extend load result   req_addr_51   byte address
//   req_wdata_51    store data, right-justified
//   rsp_valid_51    one-cycle completion      rsp_rdata_51  load result (0 otherwise)
//   rsp_err_51      request rejected
//   waddr_51/wdata_51/write_51   memory write port
//   raddr_51/rdata_51            memory read port
//
// Build option
//   MEM_ACCESS_51_ERR_EN  when defined, misaligned, size-11 and out-of-range
//                         requests complete straight away with rsp_err_51 = 1
//                         and no memory access. When undefined, rsp_err_51 is
//                         0, low address bits below the access size are
//                         ignored and size 11 behaves as a word.
// -----------------------------------------------------------------------------
module mem_access_51 #(
    parameter int unsigned ADDR_LIMIT = 2000
) (
    input  logic        clk_51,
    input  logic        rst_n_51,
    input  logic        req_valid_51,
    output logic        req_ready_51,
    input  logic        req_we_51,
    input  logic [1:0]  req_size_51,
    input  logic        req_signed_51,
    input  logic [31:0] req_addr_51,
    input  logic [31:0] req_wdata_51,
    output logic        rsp_valid_51,
    output logic [31:0] rsp_rdata_51,
    output logic        rsp_err_51,
    output logic [31:0] waddr_51,
    output logic [31:0] wdata_51,
    output logic        write_51,
    output logic [31:0] raddr_51,
    input  logic [31:0] rdata_51
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state;
    logic [1:0]  size_q;      // normalised size: 00 byte, 01 half, 10 word
    logic [1:0]  lane_q;      // byte lane of the access, already aligned to size
    logic        signed_q;
    logic        we_q;
    logic [31:0] wdata_q;

    logic [31:0] req_index;
    logic [1:0]  req_size_eff;
    logic [1:0]  req_lane_eff;
    logic        req_err;
    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [31:0] lane_mask;
    logic [31:0] load_data;
    logic [31:0] merge_data;

    // NOTE: every signal driven here gets a value on every path (defaults
    // first, or full case coverage), otherwise synthesis infers latches.
    always_comb begin
        req_index    = {2'b00, req_addr_51[31:2]};
        req_size_eff = (req_size_51 == 2'b11) ? 2'b10 : req_size_51;

        // Address bits below the access size do not select anything.
        case (req_size_eff)
            2'b00:   req_lane_eff = req_addr_51[1:0];
            2'b01:   req_lane_eff = {req_addr_51[1], 1'b0};
            default: req_lane_eff = 2'b00;
        endcase

        req_err = 1'b0;
`ifdef MEM_ACCESS_51_ERR_EN
        req_err = (req_size_51 == 2'b11)
               || (req_size_51 == 2'b01 && req_addr_51[0])
               || (req_size_51 == 2'b10 && req_addr_51[1:0] != 2'b00)
               || (req_index > ADDR_LIMIT);
`endif

        // Lane extraction for loads and lane merge for sub-word stores both
        // work on the word currently returned by the memory.
        shamt   = {lane_q, 3'b000};
        shifted = rdata_51 >> shamt;
        case (size_q)
            2'b00: begin
                load_data = {{24{signed_q & shifted[7]}}, shifted[7:0]};
                lane_mask = 32'h0000_00FF << shamt;
            end
            2'b01: begin
                load_data = {{16{signed_q & shifted[15]}}, shifted[15:0]};
                lane_mask = 32'h0000_FFFF << shamt;
            end
            default: begin
                load_data = shifted;
                lane_mask = 32'hFFFF_FFFF;
            end
        endcase
        merge_data = (rdata_51 & ~lane_mask) | ((wdata_q << shamt) & lane_mask);
    end

    // NOTE: state and outputs use non-blocking assignments so every register
    // updates from values sampled at the same clock edge.
    always_ff @(posedge clk_51) begin
        if (!rst_n_51) begin
            // NOTE: the captured request fields are cleared too; they are only
            // consulted after a fresh capture, but a known value keeps the
            // merge/extract datapath free of X after reset.
            state        <= IDLE;
            req_ready_51 <= 1'b1;
            rsp_valid_51 <= 1'b0;
            rsp_err_51   <= 1'b0;
            rsp_rdata_51 <= 32'h0;
            write_51     <= 1'b0;
            waddr_51     <= 32'h0;
            wdata_51     <= 32'h0;
            raddr_51     <= 32'h0;
            size_q       <= 2'b00;
            lane_q       <= 2'b00;
            signed_q     <= 1'b0;
            we_q         <= 1'b0;
            wdata_q      <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_51 && req_ready_51) begin
                        req_ready_51 <= 1'b0;
                        size_q       <= req_size_eff;
                        lane_q       <= req_lane_eff;
                        signed_q     <= req_signed_51;
                        we_q         <= req_we_51;
                        wdata_q      <= req_wdata_51;
                        if (req_err) begin
                            state        <= RESP;
                            rsp_valid_51 <= 1'b1;
                            rsp_err_51   <= 1'b1;
                            rsp_rdata_51 <= 32'h0;
                        end else if (req_we_51 && req_size_eff[1]) begin
                            // Full-word store needs no old data.
                            state    <= WRITE;
                            raddr_51 <= req_index;
                            write_51 <= 1'b1;
                            waddr_51 <= req_index;
                            wdata_51 <= req_wdata_51;
                        end else begin
                            state    <= READ;
                            raddr_51 <= req_index;
                        end
                    end
                end
                READ: begin
                    if (we_q) begin
                        state    <= WRITE;
                        write_51 <= 1'b1;
                        waddr_51 <= raddr_51;
                        wdata_51 <= merge_data;
                    end else begin
                        state        <= RESP;
                        rsp_valid_51 <= 1'b1;
                        rsp_rdata_51 <= load_data;
                    end
                end
                WRITE: begin
                    state        <= RESP;
                    write_51     <= 1'b0;
                    rsp_valid_51 <= 1'b1;
                    rsp_rdata_51 <= 32'h0;
                end
                RESP: begin
                    state        <= IDLE;
                    req_ready_51 <= 1'b1;
                    rsp_valid_51 <= 1'b0;
                    rsp_err_51   <= 1'b0;
                    rsp_rdata_51 <= 32'h0;
                    raddr_51     <= 32'h0;
                end
                default: begin
                    state        <= IDLE;
                    req_ready_51 <= 1'b1;
                    rsp_valid_51 <= 1'b0;
                    rsp_err_51   <= 1'b0;
                    write_51     <= 1'b0;
                    raddr_51     <= 32'h0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_51.sv
// -----------------------------------------------------------------------------
// tb_mem_access_51 -- bench for mem_access_51 with an attached behavioural data
// memory. A driver issues directed and random requests; for each accepted
// request a byte-level reference model pushes the expected response (data,
// error, response cycle, write count, write address/data) into a queue, and a
// separate monitor pops and compares whenever rsp_valid_51 is seen.
// -----------------------------------------------------------------------------
module tb_mem_access_51;

    localparam int unsigned LIMIT = 2000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        write;
    logic [31:0] raddr;
    logic [31:0] rdata;

    always #5 clk = ~clk;

    mem_access_51 #(.ADDR_LIMIT(LIMIT)) dut (
        .clk_51        (clk),
        .rst_n_51      (rst_n),
        .req_valid_51  (req_valid),
        .req_ready_51  (req_ready),
        .req_we_51     (req_we),
        .req_size_51   (req_size),
        .req_signed_51 (req_signed),
        .req_addr_51   (req_addr),
        .req_wdata_51  (req_wdata),
        .rsp_valid_51  (rsp_valid),
        .rsp_rdata_51  (rsp_rdata),
        .rsp_err_51    (rsp_err),
        .waddr_51      (waddr),
        .wdata_51      (wdata),
        .write_51      (write),
        .raddr_51      (raddr),
        .rdata_51      (rdata)
    );

    // Attached data memory and the reference model's own image of it.
    logic [31:0] mem     [0:LIMIT];
    logic [31:0] ref_mem [0:LIMIT];

    assign rdata = (raddr <= LIMIT) ? mem[raddr[10:0]] : 32'h0;

    always @(posedge clk)
        if (write && waddr <= LIMIT) mem[waddr[10:0]] <= wdata;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          rsp_cyc;
        int          writes;
        logic [31:0] waddr;
        logic [31:0] wdata;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_bad    = 0;
    int   wcount   = 0;
    bit   abort_window = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: works on the four bytes of the addressed word.
    task automatic model(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wd, output exp_t e);
        int          idx;
        int          lane;
        int          hw;
        logic [7:0]  b [4];
        logic [31:0] old;
        logic [31:0] r;
        bit          err;
        idx  = int'(addr >> 2);
        lane = int'(addr[1:0]);
        hw   = lane / 2;
        err  = 1'b0;
`ifdef MEM_ACCESS_51_ERR_EN
        err = (size == 2'b11) || (size == 2'b01 && addr[0])
           || (size == 2'b10 && addr[1:0] != 2'b00) || (idx > int'(LIMIT));
`endif
        e.err    = err;
        e.rdata  = 32'h0;
        e.writes = 0;
        e.waddr  = addr >> 2;
        e.wdata  = 32'h0;
        e.lat    = 0;
        if (!err) begin
            old = ref_mem[idx];
            for (int i = 0; i < 4; i++) b[i] = old[8*i +: 8];
            if (!we) begin
                e.lat = 1;
                case (size)
                    2'b00: begin
                        r = {24'h0, b[lane]};
                        if (sgn && b[lane] >= 8'd128) r = r | 32'hFFFF_FF00;
                    end
                    2'b01: begin
                        r = {16'h0, b[2*hw+1], b[2*hw]};
                        if (sgn && b[2*hw+1] >= 8'd128) r = r | 32'hFFFF_0000;
                    end
                    default: r = old;
                endcase
                e.rdata = r;
            end else begin
                case (size)
                    2'b00: b[lane] = wd[7:0];
                    2'b01: begin
                        b[2*hw]   = wd[7:0];
                        b[2*hw+1] = wd[15:8];
                    end
                    default: for (int i = 0; i < 4; i++) b[i] = wd[8*i +: 8];
                endcase
                ref_mem[idx] = {b[3], b[2], b[1], b[0]};
                e.writes = 1;
                e.wdata  = {b[3], b[2], b[1], b[0]};
                e.lat    = (size == 2'b00 || size == 2'b01) ? 2 : 1;
            end
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge,
    // leaving req_valid high with junk to show it is ignored while busy.
    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wd);
        exp_t e;
        int   w;
        w = 0;
        while (!req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) begin
            check("ready_timeout", {31'h0, req_ready}, 32'h1);
            return;
        end
        check("raddr_idle", raddr, 32'h0);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wd;
        model(we, size, sgn, addr, wd, e);
        e.rsp_cyc = cyc + 1 + e.lat;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        req_we    = $urandom_range(0, 1) == 1;
        req_size  = 2'($urandom_range(0, 3));
        req_addr  = $urandom;
        req_wdata = $urandom;
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int n);
        req_valid = 1'b0;
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Monitor: compares every write and every response against the queue head.
    always @(negedge clk) begin
        if (abort_window) begin
            check("abort_write", {31'h0, write}, 32'h0);
            check("abort_rsp", {31'h0, rsp_valid}, 32'h0);
        end else if (rst_n) begin
            if (write) begin
                wcount++;
                if (sbq.size() == 0) check("unexpected_write", 32'h1, 32'h0);
                else begin
                    check("waddr", waddr, sbq[0].waddr);
                    check("wdata", wdata, sbq[0].wdata);
                end
            end
            if (rsp_valid) begin
                if (sbq.size() == 0) check("unexpected_rsp", 32'h1, 32'h0);
                else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
                    check("rsp_cycle", cyc, e.rsp_cyc);
                    check("write_count", wcount, e.writes);
                end
                wcount = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w;
        int          diffs;
        logic [31:0] old;

        for (int i = 0; i <= int'(LIMIT); i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        repeat (3) @(negedge clk);

        check("rst_ready", {31'h0, req_ready}, 32'h1);
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_write", {31'h0, write}, 32'h0);
        check("rst_waddr", waddr, 32'h0);
        check("rst_wdata", wdata, 32'h0);
        check("rst_raddr", raddr, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Word store to 0x68.
        do_req(1'b1, 2'b10, 1'b0, 32'h68, 32'hDEAD_BEEF);
        idle_cycles(3);
        check("sw_mem", mem[26], 32'hDEAD_BEEF);

        // Loads from a preloaded word.
        mem[26] = 32'h0000_80F1;
        ref_mem[26] = 32'h0000_80F1;
        do_req(1'b0, 2'b00, 1'b1, 32'h68, 32'h0);   // lb
        do_req(1'b0, 2'b01, 1'b0, 32'h68, 32'h0);   // lhu
        do_req(1'b0, 2'b01, 1'b1, 32'h68, 32'h0);   // lh
        idle_cycles(3);

        // Byte store into a preloaded word, then read it back back-to-back.
        mem[26] = 32'h1122_3344;
        ref_mem[26] = 32'h1122_3344;
        do_req(1'b1, 2'b00, 1'b0, 32'h6A, 32'h0000_00AB);
        do_req(1'b0, 2'b10, 1'b0, 32'h68, 32'h0);
        idle_cycles(3);
        check("sb_merge", mem[26], 32'h11AB_3344);

        // Reset while a halfword store is in its read phase.
        old = mem[28];
        do_req(1'b1, 2'b01, 1'b0, 32'h70, ~old);
        void'(sbq.pop_back());
        ref_mem[28] = old;
        abort_window = 1'b1;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_ready", {31'h0, req_ready}, 32'h1);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        abort_window = 1'b0;
        wcount = 0;
        check("abort_mem", mem[28], old);

`ifdef MEM_ACCESS_51_ERR_EN
        do_req(1'b0, 2'b10, 1'b0, 32'h6A, 32'h0);
        do_req(1'b0, 2'b10, 1'b0, 32'(2001 * 4), 32'h0);
        do_req(1'b1, 2'b11, 1'b0, 32'h40, 32'h5555_5555);
        idle_cycles(2);
`endif

        // Random traffic concentrated on a few words plus the top index.
        for (int n = 0; n < 300; n++) begin
            int          idx;
            logic [31:0] a;
            idx = ($urandom_range(0, 7) == 0) ? int'(LIMIT) : int'($urandom_range(0, 15));
`ifdef MEM_ACCESS_51_ERR_EN
            if ($urandom_range(0, 19) == 0) idx = int'(LIMIT) + 1;
`endif
            a = (32'(idx) << 2) | 32'($urandom_range(0, 3));
            do_req($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
                   $urandom_range(0, 1) == 1, a, $urandom);
            if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 3)));
        end
        idle_cycles(1);

        w = 0;
        while (sbq.size() != 0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("drain", sbq.size(), 32'h0);

        diffs = 0;
        for (int i = 0; i <= int'(LIMIT); i++)
            if (mem[i] !== ref_mem[i]) diffs++;
        check("mem_image", diffs, 32'h0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
